// File: rtl/axi4_lite_master_seq.sv
// Single-outstanding AXI4-Lite master: turns one command into one AW+W/B or AR/R
// transaction and reports completion with a one-cycle rsp_valid pulse.
module axi4_lite_master_seq #(
  parameter int ADDR_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  // response side
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  // AXI4-Lite write channels
  output logic [ADDR_W-1:0] M_AWADDR,
  output logic              M_AWVALID,
  input  logic              M_AWREADY,
  output logic [31:0]       M_WDATA,
  output logic [3:0]        M_WSTRB,
  output logic              M_WVALID,
  input  logic              M_WREADY,
  input  logic [1:0]        M_BRESP,
  input  logic              M_BVALID,
  output logic              M_BREADY,
  // AXI4-Lite read channels
  output logic [ADDR_W-1:0] M_ARADDR,
  output logic              M_ARVALID,
  input  logic              M_ARREADY,
  input  logic [31:0]       M_RDATA,
  input  logic [1:0]        M_RRESP,
  input  logic              M_RVALID,
  output logic              M_RREADY
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WADDR_DATA = 3'd1;
  localparam logic [2:0] WRESP      = 3'd2;
  localparam logic [2:0] RADDR      = 3'd3;
  localparam logic [2:0] RDATA      = 3'd4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
  } cmd_t;

  logic [2:0] state;
  cmd_t       cmd_q;
  logic       rst_q;
  logic       awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic       accept, aw_ok, w_ok;

  // rst_q keeps cmd_ready low for every cycle that follows a reset edge
  assign cmd_ready = (state == IDLE) && !rst_q;
  assign accept    = cmd_valid && cmd_ready;

  // a channel is finished once its VALID is gone or is being taken this cycle
  assign aw_ok = !awvalid_q || M_AWREADY;
  assign w_ok  = !wvalid_q  || M_WREADY;

  assign M_AWADDR  = cmd_q.addr;
  assign M_ARADDR  = cmd_q.addr;
  assign M_WDATA   = cmd_q.wdata;
  assign M_WSTRB   = cmd_q.wstrb;
  assign M_AWVALID = awvalid_q;
  assign M_WVALID  = wvalid_q;
  assign M_BREADY  = bready_q;
  assign M_ARVALID = arvalid_q;
  assign M_RREADY  = rready_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      rst_q     <= 1'b1;
      cmd_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_resp  <= 2'b00;
      rsp_rdata <= 32'h0;
    end else begin
      rst_q     <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_q.addr  <= cmd_addr;
            cmd_q.wdata <= cmd_wdata;
            cmd_q.wstrb <= cmd_wstrb;
            if (cmd_write) begin
              state     <= WADDR_DATA;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state     <= RADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        WADDR_DATA: begin
          if (awvalid_q && M_AWREADY) awvalid_q <= 1'b0;
          if (wvalid_q && M_WREADY)   wvalid_q  <= 1'b0;
          if (aw_ok && w_ok) begin
            state    <= WRESP;
            bready_q <= 1'b1;
          end
        end
        WRESP: begin
          if (M_BVALID) begin
            state     <= IDLE;
            bready_q  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_resp  <= M_BRESP;
            rsp_rdata <= 32'h0;
          end
        end
        RADDR: begin
          if (M_ARREADY) begin
            state     <= RDATA;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        RDATA: begin
          if (M_RVALID) begin
            state     <= IDLE;
            rready_q  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_resp  <= M_RRESP;
            rsp_rdata <= M_RDATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master_seq.sv
// Bench for axi4_lite_master_seq: delay-configurable slave, a timeline model built from
// per-transaction cycle windows, and hand-computed pins on key cycles.
module tb_axi4_lite_master_seq;
  localparam int MAXT = 32;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] M_AWADDR, M_WDATA, M_ARADDR;
  logic        M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY;
  logic [3:0]  M_WSTRB;
  logic        M_AWREADY = 0, M_WREADY = 0, M_BVALID = 0, M_ARREADY = 0, M_RVALID = 0;
  logic [1:0]  M_BRESP = 0, M_RRESP = 0;
  logic [31:0] M_RDATA = 0;

  always #5 ACLK = ~ACLK;

  axi4_lite_master_seq #(.ADDR_W(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int errs = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- model: one record per issued command ----------------
  int          ntx = 0;
  bit          m_wr   [MAXT];
  int          m_t0   [MAXT];
  int          m_da   [MAXT];
  int          m_dw   [MAXT];
  int          m_dd   [MAXT];
  int          m_kill [MAXT];
  logic [1:0]  m_resp [MAXT];
  logic [31:0] m_rdata[MAXT];
  logic [31:0] m_addr [MAXT];
  logic [31:0] m_wdata[MAXT];
  logic [3:0]  m_wstrb[MAXT];
  int          rst_cyc[$];

  typedef struct {int c; int kind; logic [1:0] resp; logic [31:0] rdata;} pin_t;
  pin_t pins[$];

  function automatic int mx(input int a, input int b); return (a > b) ? a : b; endfunction
  function automatic int mn(input int a, input int b); return (a < b) ? a : b; endfunction

  // cycle in which rsp_valid must be high, counted from the cycle the command was presented
  function automatic int rsp_c(input int i);
    if (m_wr[i]) return m_t0[i] + 3 + mx(m_da[i], m_dw[i]) + m_dd[i];
    return m_t0[i] + 3 + m_da[i] + m_dd[i];
  endfunction

  function automatic bit in_win(input int i, input int c, input int lo, input int hi);
    return (c < m_kill[i]) && (c >= lo) && (c <= hi);
  endfunction

  function automatic bit is_rst(input int c);
    foreach (rst_cyc[k]) if (rst_cyc[k] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int last_rst(input int c);
    int r = -1;
    foreach (rst_cyc[k]) if (rst_cyc[k] <= c) r = mx(r, rst_cyc[k]);
    return r;
  endfunction

  task automatic add_pin(input int c, input int kind, input logic [1:0] resp, input logic [31:0] rd);
    pin_t p;
    p.c = c; p.kind = kind; p.resp = resp; p.rdata = rd;
    pins.push_back(p);
  endtask

  task automatic check_cycle(input int c);
    bit rn, busy, aw, w, b, ar, rr, rv;
    int r, li, ai, m, rc;
    logic [1:0]  e_resp;
    logic [31:0] e_rdata, e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    rn = is_rst(c); r = last_rst(c);
    busy = 0; aw = 0; w = 0; b = 0; ar = 0; rr = 0; rv = 0; li = -1; ai = -1;
    for (int i = 0; i < ntx; i++) begin
      rc = rsp_c(i);
      m  = mx(m_da[i], m_dw[i]);
      if (m_t0[i] < c && c < rc && c < m_kill[i]) busy = 1;
      if (m_wr[i]) begin
        aw |= in_win(i, c, m_t0[i] + 1, m_t0[i] + 1 + m_da[i]);
        w  |= in_win(i, c, m_t0[i] + 1, m_t0[i] + 1 + m_dw[i]);
        b  |= in_win(i, c, m_t0[i] + 2 + m, m_t0[i] + 2 + m + m_dd[i]);
      end else begin
        ar |= in_win(i, c, m_t0[i] + 1, m_t0[i] + 1 + m_da[i]);
        rr |= in_win(i, c, m_t0[i] + 2 + m_da[i], m_t0[i] + 2 + m_da[i] + m_dd[i]);
      end
      if (rc < m_kill[i] && rc <= c) begin
        if (rc == c) rv = 1;
        if (li < 0 || rc > rsp_c(li)) li = i;
      end
      if (m_t0[i] + 1 <= c && (ai < 0 || m_t0[i] > m_t0[ai])) ai = i;
    end
    e_resp = 2'b00; e_rdata = 32'h0;
    if (li >= 0 && rsp_c(li) > r) begin
      e_resp  = m_resp[li];
      e_rdata = m_wr[li] ? 32'h0 : m_rdata[li];
    end
    e_addr = 32'h0; e_wdata = 32'h0; e_wstrb = 4'h0;
    if (ai >= 0 && m_t0[ai] + 1 > r) begin
      e_addr = m_addr[ai]; e_wdata = m_wdata[ai]; e_wstrb = m_wstrb[ai];
    end
    chk("cmd_ready", {31'h0, cmd_ready}, {31'h0, !rn && !busy});
    chk("awvalid",   {31'h0, M_AWVALID}, {31'h0, aw});
    chk("wvalid",    {31'h0, M_WVALID},  {31'h0, w});
    chk("bready",    {31'h0, M_BREADY},  {31'h0, b});
    chk("arvalid",   {31'h0, M_ARVALID}, {31'h0, ar});
    chk("rready",    {31'h0, M_RREADY},  {31'h0, rr});
    chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, rv});
    chk("rsp_resp",  {30'h0, rsp_resp},  {30'h0, e_resp});
    chk("rsp_rdata", rsp_rdata, e_rdata);
    chk("awaddr",    M_AWADDR, e_addr);
    chk("araddr",    M_ARADDR, e_addr);
    if (w || rn) begin
      chk("wdata", M_WDATA, e_wdata);
      chk("wstrb", {28'h0, M_WSTRB}, {28'h0, e_wstrb});
    end
    foreach (pins[k]) if (pins[k].c == c) begin
      case (pins[k].kind)
        0: begin
          chk("pin_rsp_valid", {31'h0, rsp_valid}, 32'h1);
          chk("pin_rsp_resp",  {30'h0, rsp_resp}, {30'h0, pins[k].resp});
          chk("pin_rsp_rdata", rsp_rdata, pins[k].rdata);
        end
        1: chk("pin_no_rsp", {31'h0, rsp_valid}, 32'h0);
        default: chk("pin_reset_zero",
                     {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid, rsp_resp,
                      cmd_ready, rsp_rdata | M_ARADDR | M_WDATA},
                     32'h0);
      endcase
    end
  endtask

  initial forever begin
    @(negedge ACLK);
    if (rst_cyc.size() > 0 && cyc >= rst_cyc[0]) check_cycle(cyc);
  end

  // ---------------- slave: READY/VALID after configured waits ----------------
  int          s_da = 0, s_dw = 0, s_dd = 0;
  logic [1:0]  s_resp = 0;
  bit          s_stray_b = 0, s_stray_r = 0;
  logic [31:0] mem [16];

  initial begin
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    foreach (mem[k]) mem[k] = 32'h0;
    forever begin
      @(negedge ACLK);
      if (M_AWVALID) begin M_AWREADY = (aw_cnt >= s_da); aw_cnt++; end
      else begin M_AWREADY = 0; aw_cnt = 0; end
      if (M_WVALID) begin
        M_WREADY = (w_cnt >= s_dw);
        if (M_WREADY)
          for (int k = 0; k < 4; k++)
            if (M_WSTRB[k]) mem[M_AWADDR[5:2]][8*k +: 8] = M_WDATA[8*k +: 8];
        w_cnt++;
      end else begin M_WREADY = 0; w_cnt = 0; end
      if (M_ARVALID) begin M_ARREADY = (ar_cnt >= s_da); ar_cnt++; end
      else begin M_ARREADY = 0; ar_cnt = 0; end
      if (M_BREADY) begin M_BVALID = (b_cnt >= s_dd); b_cnt++; end
      else begin M_BVALID = s_stray_b; b_cnt = 0; end
      if (M_RREADY) begin M_RVALID = (r_cnt >= s_dd); r_cnt++; M_RDATA = mem[M_ARADDR[5:2]]; end
      else begin M_RVALID = s_stray_r; r_cnt = 0; M_RDATA = 32'hBAD0BAD0; end
      M_BRESP = s_resp;
      M_RRESP = s_resp;
    end
  end

  // ---------------- driver ----------------
  function automatic int next_free();
    int f = 0;
    for (int i = 0; i < ntx; i++) f = mx(f, mn(rsp_c(i), m_kill[i]));
    foreach (rst_cyc[k]) f = mx(f, rst_cyc[k] + 1);
    return f;
  endfunction

  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int da, input int dw, input int dd,
                        input logic [1:0] resp, input logic [31:0] exp_rd, input bit stray,
                        output int t0);
    int free, guard;
    free = next_free(); guard = 0;
    while (cyc < free && guard < 200) begin @(negedge ACLK); guard++; end
    if (guard >= 200) begin
      checks++; errs++;
      $display("FAIL issue_timeout cyc=%0d actual=busy required=idle", cyc);
    end
    s_da = da; s_dw = dw; s_dd = dd; s_resp = resp;
    s_stray_b = !wr && stray; s_stray_r = wr && stray;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    m_wr[ntx] = wr; m_t0[ntx] = cyc; m_da[ntx] = da; m_dw[ntx] = dw; m_dd[ntx] = dd;
    m_kill[ntx] = 1 << 30; m_resp[ntx] = resp; m_rdata[ntx] = exp_rd;
    m_addr[ntx] = addr; m_wdata[ntx] = data; m_wstrb[ntx] = strb;
    t0 = cyc; ntx++;
    @(negedge ACLK);
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
  endtask

  task automatic do_reset(input int n);
    ARESET = 1;
    for (int k = 1; k <= n; k++) rst_cyc.push_back(cyc + k);
    for (int i = 0; i < ntx; i++) m_kill[i] = mn(m_kill[i], cyc + 1);
    repeat (n) @(negedge ACLK);
    ARESET = 0;
  endtask

  initial begin
    int t, fin, guard;
    @(negedge ACLK);
    do_reset(3);
    // zero-wait write then back-to-back readback
    do_txn(1, 32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'd0, 32'h0, 0, t);
    add_pin(t + 3, 0, 2'd0, 32'h0);
    add_pin(t + 6, 0, 2'd0, 32'hDEADBEEF);
    do_txn(0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 2'd0, 32'hDEADBEEF, 0, t);
    // AWREADY late by 3, partial strobe
    do_txn(1, 32'h8, 32'h12345678, 4'h3, 3, 0, 0, 2'd0, 32'h0, 1, t);
    add_pin(t + 6, 0, 2'd0, 32'h0);
    do_txn(0, 32'h8, 32'h0, 4'h0, 0, 0, 0, 2'd0, 32'h00005678, 1, t);
    add_pin(t + 3, 0, 2'd0, 32'h00005678);
    // BVALID late by 5, then SLVERR read back-to-back
    do_txn(1, 32'hC, 32'hA5A5A5A5, 4'hF, 0, 0, 5, 2'd0, 32'h0, 1, t);
    add_pin(t + 8, 0, 2'd0, 32'h0);
    add_pin(t + 11, 0, 2'd2, 32'hA5A5A5A5);
    do_txn(0, 32'hC, 32'h0, 4'h0, 0, 0, 0, 2'd2, 32'hA5A5A5A5, 1, t);
    // W later than AW, DECERR passthrough
    do_txn(1, 32'h14, 32'h11223344, 4'hC, 1, 2, 0, 2'd3, 32'h0, 0, t);
    add_pin(t + 5, 0, 2'd3, 32'h0);
    // reset while waiting for RVALID
    do_txn(0, 32'h4, 32'h0, 4'h0, 0, 0, 6, 2'd0, 32'hDEADBEEF, 0, t);
    add_pin(t + 4, 2, 2'd0, 32'h0);
    add_pin(t + 9, 1, 2'd0, 32'h0);
    repeat (2) @(negedge ACLK);
    do_reset(1);
    do_txn(1, 32'h10, 32'hCAFEF00D, 4'hF, 0, 0, 0, 2'd0, 32'h0, 0, t);
    add_pin(t + 3, 0, 2'd0, 32'h0);
    do_txn(0, 32'h10, 32'h0, 4'h0, 2, 0, 1, 2'd0, 32'hCAFEF00D, 0, t);
    add_pin(t + 6, 0, 2'd0, 32'hCAFEF00D);
    do_txn(0, 32'h14, 32'h0, 4'h0, 0, 0, 0, 2'd0, 32'h11220000, 0, t);
    add_pin(t + 3, 0, 2'd0, 32'h11220000);
    fin = next_free() + 3; guard = 0;
    while (cyc < fin && guard < 200) begin @(negedge ACLK); guard++; end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #50000;
    errs++; checks++;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
